// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit with long-op scoreboard, ebreak halt/resume control
// and a saturating stall-cycle counter for a five-stage RV32IM core.
module hazard_unit_sb #(
    parameter int unsigned  NREG     = 32,
    parameter int unsigned  MAX_LONG = 2,
    parameter int unsigned  CNT_W    = 32,
    localparam int unsigned AW       = $clog2(NREG),
    localparam int unsigned SW       = $clog2(MAX_LONG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr_D,
    input  logic [AW-1:0]    rs2_addr_D,
    input  logic [AW-1:0]    rd_D,
    input  logic             rs1_valid_D,
    input  logic             rs2_valid_D,
    input  logic             we_D,
    input  logic             branch_or_jump_D,
    input  logic [AW-1:0]    rs1_addr_E,
    input  logic [AW-1:0]    rs2_addr_E,
    input  logic             rs1_valid_E,
    input  logic             rs2_valid_E,
    input  logic [AW-1:0]    rd_E,
    input  logic [AW-1:0]    rd_M,
    input  logic [AW-1:0]    rd_W,
    input  logic             we_E,
    input  logic             we_M,
    input  logic             we_W,
    input  logic             ld_E,
    input  logic             ld_M,
    input  logic             ld_W,
    input  logic             PCnew_E,
    input  logic             ebreak_E,
    input  logic             long_issue_E,
    input  logic             long_done,
    input  logic [AW-1:0]    long_rd,
    input  logic             resume_i,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [1:0]       ForwardAD,
    output logic [1:0]       ForwardBD,
    output logic             PC_ce,
    output logic             IF_ID_ce,
    output logic             ID_EX_ce,
    output logic             EX_MEM_ce,
    output logic             MEM_WB_ce,
    output logic             IF_ID_nop,
    output logic             ID_EX_nop,
    output logic             EX_MEM_nop,
    output logic             halted,
    output logic [NREG-1:0]  sb_busy,
    output logic [SW-1:0]    sb_cnt,
    output logic             sb_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_RESUME = 2'd2
    } state_e;

    state_e           state_q;
    logic [NREG-1:0]  sb_busy_q, sb_busy_d;
    logic [SW-1:0]    sb_cnt_q;
    logic             sb_err_q, sb_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [2:0] fa_e, fb_e, fa_d, fb_d;
    logic       sb_stall, long_full, e_stall, d_stall, e_adv;

    // A branch operand ignores a load in E because it stalls on any E hit anyway.
    logic unused_ld_e;
    assign unused_ld_e = ld_E;

    // Result {stall, sel[1:0]}: M beats W, a load in M cannot be forwarded yet.
    function automatic logic [2:0] fwd_mw(
        input logic          v,
        input logic [AW-1:0] a,
        input logic [AW-1:0] rdm,
        input logic          wem,
        input logic          ldm,
        input logic [AW-1:0] rdw,
        input logic          wew,
        input logic          ldw
    );
        logic [2:0] r;
        r = 3'b000;
        if (v && (a != '0)) begin
            if (wem && (a == rdm))      r = ldm ? 3'b100 : 3'b010;
            else if (wew && (a == rdw)) r = ldw ? 3'b001 : 3'b011;
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] popcnt(input logic [NREG-1:0] v);
        logic [SW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NREG; i++) c = c + SW'(v[i]);
        return c;
    endfunction

    // Hazard detection shared by outputs and state update.
    always_comb begin
        fa_e = fwd_mw(rs1_valid_E, rs1_addr_E, rd_M, we_M, ld_M, rd_W, we_W, ld_W);
        fb_e = fwd_mw(rs2_valid_E, rs2_addr_E, rd_M, we_M, ld_M, rd_W, we_W, ld_W);
        fa_d = 3'b000;
        fb_d = 3'b000;
        if (branch_or_jump_D) begin
            if (rs1_valid_D && (rs1_addr_D != '0) && we_E && (rs1_addr_D == rd_E))
                fa_d = 3'b100;
            else
                fa_d = fwd_mw(rs1_valid_D, rs1_addr_D, rd_M, we_M, ld_M, rd_W, we_W, ld_W);
            if (rs2_valid_D && (rs2_addr_D != '0) && we_E && (rs2_addr_D == rd_E))
                fb_d = 3'b100;
            else
                fb_d = fwd_mw(rs2_valid_D, rs2_addr_D, rd_M, we_M, ld_M, rd_W, we_W, ld_W);
        end
        sb_stall = (rs1_valid_D && (rs1_addr_D != '0) && sb_busy_q[rs1_addr_D])
                 | (rs2_valid_D && (rs2_addr_D != '0) && sb_busy_q[rs2_addr_D])
                 | (we_D && (rd_D != '0) && sb_busy_q[rd_D]);
        long_full = (sb_cnt_q == SW'(MAX_LONG));
        e_stall   = fa_e[2] | fb_e[2] | (long_issue_E & long_full);
        d_stall   = fa_d[2] | fb_d[2] | sb_stall;
        e_adv     = !e_stall && (state_q == ST_RUN);
    end

    // Stage controls: HALT > E-stall > redirect > D-stall; defaults while in reset.
    always_comb begin
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        ForwardAD  = 2'b00;
        ForwardBD  = 2'b00;
        PC_ce      = 1'b1;
        IF_ID_ce   = 1'b1;
        ID_EX_ce   = 1'b1;
        EX_MEM_ce  = 1'b1;
        MEM_WB_ce  = 1'b1;
        IF_ID_nop  = 1'b0;
        ID_EX_nop  = 1'b0;
        EX_MEM_nop = 1'b0;
        if (!rst) begin
            ForwardAE = fa_e[1:0];
            ForwardBE = fb_e[1:0];
            ForwardAD = fa_d[1:0];
            ForwardBD = fb_d[1:0];
            if ((state_q == ST_HALT) || e_stall) begin
                PC_ce      = 1'b0;
                IF_ID_ce   = 1'b0;
                ID_EX_ce   = 1'b0;
                EX_MEM_nop = 1'b1;
            end else if (PCnew_E) begin
                IF_ID_nop = 1'b1;
                ID_EX_nop = 1'b1;
                ForwardAD = 2'b00;
                ForwardBD = 2'b00;
            end else if (d_stall) begin
                PC_ce     = 1'b0;
                IF_ID_ce  = 1'b0;
                ID_EX_nop = 1'b1;
            end
        end
    end

    // Scoreboard and counter next state; a same-cycle issue overrides the clear.
    always_comb begin
        sb_busy_d   = sb_busy_q;
        sb_err_d    = sb_err_q;
        stall_cnt_d = stall_cnt_q;
        if (long_done) begin
            if (sb_busy_q[long_rd]) sb_busy_d[long_rd] = 1'b0;
            else                    sb_err_d = 1'b1;
        end
        if (long_issue_E && e_adv && (rd_E != '0))
            sb_busy_d[rd_E] = 1'b1;
        if (!PC_ce && (state_q != ST_HALT) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            sb_busy_q   <= '0;
            sb_cnt_q    <= '0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN:    if (ebreak_E && e_adv) state_q <= ST_HALT;
                ST_HALT:   if (resume_i) state_q <= ST_RESUME;
                ST_RESUME: state_q <= ST_RUN;
                default:   state_q <= ST_RUN;
            endcase
            sb_busy_q   <= sb_busy_d;
            sb_cnt_q    <= popcnt(sb_busy_d);
            sb_err_q    <= sb_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halted    = (state_q == ST_HALT);
    assign sb_busy   = sb_busy_q;
    assign sb_cnt    = sb_cnt_q;
    assign sb_err    = sb_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb; a narrow stall counter exposes saturation.
module tb_hazard_unit_sb;

    localparam int unsigned NREG     = 32;
    localparam int unsigned MAX_LONG = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned AW       = 5;
    localparam int unsigned SW       = 2;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] rs1_addr_D, rs2_addr_D, rd_D;
    logic rs1_valid_D, rs2_valid_D, we_D, branch_or_jump_D;
    logic [AW-1:0] rs1_addr_E, rs2_addr_E;
    logic rs1_valid_E, rs2_valid_E;
    logic [AW-1:0] rd_E, rd_M, rd_W;
    logic we_E, we_M, we_W, ld_E, ld_M, ld_W;
    logic PCnew_E, ebreak_E, long_issue_E, long_done, resume_i;
    logic [AW-1:0] long_rd;
    logic [1:0] ForwardAE, ForwardBE, ForwardAD, ForwardBD;
    logic PC_ce, IF_ID_ce, ID_EX_ce, EX_MEM_ce, MEM_WB_ce;
    logic IF_ID_nop, ID_EX_nop, EX_MEM_nop, halted, sb_err;
    logic [NREG-1:0] sb_busy;
    logic [SW-1:0] sb_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    hazard_unit_sb #(.NREG(NREG), .MAX_LONG(MAX_LONG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D), .rd_D(rd_D),
        .rs1_valid_D(rs1_valid_D), .rs2_valid_D(rs2_valid_D), .we_D(we_D),
        .branch_or_jump_D(branch_or_jump_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rs1_valid_E(rs1_valid_E), .rs2_valid_E(rs2_valid_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .we_E(we_E), .we_M(we_M), .we_W(we_W),
        .ld_E(ld_E), .ld_M(ld_M), .ld_W(ld_W),
        .PCnew_E(PCnew_E), .ebreak_E(ebreak_E), .long_issue_E(long_issue_E),
        .long_done(long_done), .long_rd(long_rd), .resume_i(resume_i),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .PC_ce(PC_ce), .IF_ID_ce(IF_ID_ce), .ID_EX_ce(ID_EX_ce),
        .EX_MEM_ce(EX_MEM_ce), .MEM_WB_ce(MEM_WB_ce),
        .IF_ID_nop(IF_ID_nop), .ID_EX_nop(ID_EX_nop), .EX_MEM_nop(EX_MEM_nop),
        .halted(halted), .sb_busy(sb_busy), .sb_cnt(sb_cnt),
        .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic ok);
        n_chk++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs1_addr_D = '0; rs2_addr_D = '0; rd_D = '0;
        rs1_valid_D = 0; rs2_valid_D = 0; we_D = 0; branch_or_jump_D = 0;
        rs1_addr_E = '0; rs2_addr_E = '0; rs1_valid_E = 0; rs2_valid_E = 0;
        rd_E = '0; rd_M = '0; rd_W = '0;
        we_E = 0; we_M = 0; we_W = 0; ld_E = 0; ld_M = 0; ld_W = 0;
        PCnew_E = 0; ebreak_E = 0; long_issue_E = 0; long_done = 0;
        long_rd = '0; resume_i = 0;
    endtask

    initial begin
        // reset with a load-use pattern and redirect on the inputs
        rst = 1; clr();
        rs1_valid_E = 1; rs1_addr_E = 5; rd_M = 5; we_M = 1; ld_M = 1; PCnew_E = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc_ce", PC_ce === 1'b1);
        chk("rst_exmem_nop", EX_MEM_nop === 1'b0);
        chk("rst_ifid_nop", IF_ID_nop === 1'b0);
        chk("rst_fwdae", ForwardAE === 2'b00);
        chk("rst_halted", halted === 1'b0);
        chk("rst_sb_cnt", sb_cnt === 2'd0);
        chk("rst_sb_err", sb_err === 1'b0);
        chk("rst_stall_cnt", stall_cnt === 3'd0);

        // lw x5 ; add x6,x5,x7
        tick(); rst = 0; clr();
        rs1_valid_E = 1; rs1_addr_E = 5; rs2_valid_E = 1; rs2_addr_E = 7;
        rd_M = 5; we_M = 1; ld_M = 1; #1;
        chk("lu_pc_ce", PC_ce === 1'b0);
        chk("lu_idex_ce", ID_EX_ce === 1'b0);
        chk("lu_exmem_nop", EX_MEM_nop === 1'b1);
        chk("lu_idex_nop", ID_EX_nop === 1'b0);
        tick(); rd_M = 0; we_M = 0; ld_M = 0; rd_W = 5; we_W = 1; ld_W = 1; #1;
        chk("lu_fwdae_memw", ForwardAE === 2'b01);
        chk("lu_fwdbe_rf", ForwardBE === 2'b00);
        chk("lu_exmem_nop_after", EX_MEM_nop === 1'b0);
        chk("lu_stall_cnt", stall_cnt === 3'd1);

        // M ALU beats W; x0 never forwarded; W ALU select
        tick(); clr();
        rs1_valid_E = 1; rs1_addr_E = 5; rd_M = 5; we_M = 1; rd_W = 5; we_W = 1; #1;
        chk("fwd_m_over_w", ForwardAE === 2'b10);
        tick(); clr();
        rs1_valid_E = 1; rs1_addr_E = 6; rd_W = 6; we_W = 1;
        rs2_valid_E = 1; rs2_addr_E = 0; rd_M = 0; we_M = 1; #1;
        chk("fwd_alu_w", ForwardAE === 2'b11);
        chk("fwd_x0", ForwardBE === 2'b00);

        // add x5 ; beq x5,x0 in D
        tick(); clr();
        rd_E = 5; we_E = 1; branch_or_jump_D = 1;
        rs1_valid_D = 1; rs1_addr_D = 5; rs2_valid_D = 1; rs2_addr_D = 0; #1;
        chk("br_pc_ce", PC_ce === 1'b0);
        chk("br_ifid_ce", IF_ID_ce === 1'b0);
        chk("br_idex_nop", ID_EX_nop === 1'b1);
        chk("br_idex_ce", ID_EX_ce === 1'b1);
        tick(); rd_E = 0; we_E = 0; rd_M = 5; we_M = 1; #1;
        chk("br_fwdad_alum", ForwardAD === 2'b10);
        chk("br_fwdbd_rf", ForwardBD === 2'b00);
        chk("br_pc_ce_after", PC_ce === 1'b1);
        chk("br_stall_cnt", stall_cnt === 3'd2);
        tick(); ld_M = 1; #1;
        chk("br_load_m_stall", ID_EX_nop === 1'b1);
        tick(); rd_M = 0; we_M = 0; ld_M = 0; rd_W = 5; we_W = 1; ld_W = 1; #1;
        chk("br_fwdad_memw", ForwardAD === 2'b01);
        chk("br_load_stall_cnt", stall_cnt === 3'd3);

        // redirect held off by a load-use E-stall
        tick(); clr();
        rs1_valid_E = 1; rs1_addr_E = 5; rd_M = 5; we_M = 1; ld_M = 1; PCnew_E = 1; #1;
        chk("rd_held_ifid_nop", IF_ID_nop === 1'b0);
        chk("rd_held_exmem_nop", EX_MEM_nop === 1'b1);
        tick(); rd_M = 0; we_M = 0; ld_M = 0; rd_W = 5; we_W = 1; ld_W = 1;
        branch_or_jump_D = 1; rs1_valid_D = 1; rs1_addr_D = 9; rd_E = 9; we_E = 1; #1;
        chk("rd_ifid_nop", IF_ID_nop === 1'b1);
        chk("rd_idex_nop", ID_EX_nop === 1'b1);
        chk("rd_pc_ce", PC_ce === 1'b1);
        chk("rd_fwdad", ForwardAD === 2'b00);
        chk("rd_stall_cnt", stall_cnt === 3'd4);

        // three divs to x8, x9, x10 with MAX_LONG=2
        tick(); clr(); long_issue_E = 1; rd_E = 8; we_E = 1; #1;
        chk("div1_no_stall", EX_MEM_nop === 1'b0);
        tick(); rd_E = 9; #1;
        chk("div1_cnt", sb_cnt === 2'd1);
        chk("div1_busy", sb_busy === 32'h0000_0100);
        tick(); rd_E = 10;
        rs1_valid_D = 1; rs1_addr_D = 9; rs2_valid_D = 1; rs2_addr_D = 0; rd_D = 11; we_D = 1; #1;
        chk("div2_cnt", sb_cnt === 2'd2);
        chk("div3_full_stall", EX_MEM_nop === 1'b1);
        tick(); long_done = 1; long_rd = 8; #1;
        chk("div3_still_full", EX_MEM_nop === 1'b1);
        chk("div3_stall_cnt", stall_cnt === 3'd5);
        tick(); long_done = 0; #1;
        chk("done8_cnt", sb_cnt === 2'd1);
        chk("div3_issues", EX_MEM_nop === 1'b0);
        chk("add_waits_x9", ID_EX_nop === 1'b1);
        chk("done8_stall_cnt", stall_cnt === 3'd6);
        tick(); long_issue_E = 0; rd_E = 0; we_E = 0; long_done = 1; long_rd = 9; #1;
        chk("div3_cnt", sb_cnt === 2'd2);
        chk("div3_busy", sb_busy === 32'h0000_0600);
        chk("add_still_waits", ID_EX_nop === 1'b1);
        chk("div3_stall_cnt7", stall_cnt === 3'd7);
        tick(); long_done = 0; #1;
        chk("done9_cnt", sb_cnt === 2'd1);
        chk("add_advances", PC_ce === 1'b1);
        chk("add_no_bubble", ID_EX_nop === 1'b0);
        chk("stall_cnt_sat", stall_cnt === 3'd7);

        // same-cycle set/clear, spurious completion
        tick(); clr(); long_done = 1; long_rd = 10; long_issue_E = 1; rd_E = 8; we_E = 1; #1;
        chk("reissue_no_stall", EX_MEM_nop === 1'b0);
        tick(); long_done = 1; long_rd = 8; #1;
        chk("reissue_busy", sb_busy === 32'h0000_0100);
        chk("reissue_cnt", sb_cnt === 2'd1);
        tick(); long_issue_E = 0; rd_E = 0; we_E = 0; long_done = 1; long_rd = 12; #1;
        chk("setwins_busy", sb_busy === 32'h0000_0100);
        chk("setwins_no_err", sb_err === 1'b0);
        tick(); long_done = 0; #1;
        chk("spurious_err", sb_err === 1'b1);
        chk("spurious_busy", sb_busy === 32'h0000_0100);
        tick(); #1;
        chk("err_sticky", sb_err === 1'b1);

        // reset clears sticky error, busy bits and counter
        tick(); rst = 1; #1;
        tick(); rst = 0; long_issue_E = 1; rd_E = 8; we_E = 1; #1;
        chk("rst2_err", sb_err === 1'b0);
        chk("rst2_busy", sb_busy === 32'h0000_0000);
        chk("rst2_stall_cnt", stall_cnt === 3'd0);

        // ebreak with a div outstanding
        tick(); long_issue_E = 0; rd_E = 0; we_E = 0; ebreak_E = 1; #1;
        chk("eb_busy", sb_busy === 32'h0000_0100);
        chk("eb_not_halted", halted === 1'b0);
        chk("eb_pc_ce", PC_ce === 1'b1);
        tick(); long_done = 1; long_rd = 8; #1;
        chk("halt_halted", halted === 1'b1);
        chk("halt_pc_ce", PC_ce === 1'b0);
        chk("halt_idex_ce", ID_EX_ce === 1'b0);
        chk("halt_exmem_nop", EX_MEM_nop === 1'b1);
        tick(); long_done = 0; resume_i = 1; #1;
        chk("halt_done_busy", sb_busy === 32'h0000_0000);
        chk("halt_done_cnt", sb_cnt === 2'd0);
        chk("halt_still", halted === 1'b1);
        chk("halt_no_count", stall_cnt === 3'd0);
        tick(); resume_i = 0; #1;
        chk("resume_halted", halted === 1'b0);
        chk("resume_pc_ce", PC_ce === 1'b1);
        chk("resume_exmem_nop", EX_MEM_nop === 1'b0);
        tick(); ebreak_E = 0; #1;
        chk("run_after_resume", halted === 1'b0);
        chk("run_stall_cnt", stall_cnt === 3'd0);

        // reset mid-HALT with an op outstanding
        tick(); long_issue_E = 1; rd_E = 9; we_E = 1; #1;
        chk("pre_halt2", halted === 1'b0);
        tick(); long_issue_E = 0; rd_E = 0; we_E = 0; ebreak_E = 1; #1;
        chk("halt2_cnt", sb_cnt === 2'd1);
        tick(); ebreak_E = 0; rst = 1;
        rs1_valid_E = 1; rs1_addr_E = 5; rd_M = 5; we_M = 1; ld_M = 1; #1;
        chk("rsthalt_halted_reg", halted === 1'b1);
        chk("rsthalt_pc_ce", PC_ce === 1'b1);
        chk("rsthalt_idex_ce", ID_EX_ce === 1'b1);
        chk("rsthalt_exmem_nop", EX_MEM_nop === 1'b0);
        tick(); rst = 0; clr(); #1;
        chk("rsthalt_halted", halted === 1'b0);
        chk("rsthalt_busy", sb_busy === 32'h0000_0000);
        chk("rsthalt_cnt", sb_cnt === 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_sb.md
# hazard_unit_sb

Parametrised successor to the pipeline hazard unit of the five-stage RV32IM core (IF/ID/EX/MEM/WB). It produces forwarding selects and stage clock-enable/bubble controls. It adds three things the base unit lacks: a register scoreboard for an out-of-band multi-cycle mul/div unit, a halt/resume state machine for `ebreak`, and a saturating stall-cycle performance counter. Register count, outstanding long-op limit and counter width are parameters.

## Interface
- NREG, 32, architectural register count; AW = $clog2(NREG)
- MAX_LONG, 2, max outstanding mul/div ops (1..NREG-1); SW = $clog2(MAX_LONG+1)
- CNT_W, 32, stall counter width
- clk  in  1  core clock; single clock domain
- rst  in  1  synchronous, active-high reset
- rs1_addr_D, rs2_addr_D, rd_D  in  AW  decode-stage sources/destination
- rs1_valid_D, rs2_valid_D, we_D, branch_or_jump_D  in  1  decode qualifiers
- rs1_addr_E, rs2_addr_E  in  AW; rs1_valid_E, rs2_valid_E  in  1
- rd_E, rd_M, rd_W  in  AW; we_E, we_M, we_W, ld_E, ld_M, ld_W  in  1  stage writeback info
- PCnew_E, ebreak_E, long_issue_E  in  1  redirect, breakpoint, mul/div issue in EX
- long_done  in  1; long_rd  in  AW  mul/div completion (result written to RF same edge)
- resume_i  in  1  debug resume request
- ForwardAE, ForwardBE, ForwardAD, ForwardBD  out  2  00 RF, 10 ALU_M, 01 mem_W, 11 ALU_W
- PC_ce, IF_ID_ce, ID_EX_ce, EX_MEM_ce, MEM_WB_ce  out  1  stage enables
- IF_ID_nop, ID_EX_nop, EX_MEM_nop  out  1  insert bubble into that register
- halted  out  1; sb_busy  out  NREG; sb_cnt  out  SW; sb_err  out  1 sticky; stall_cnt  out  CNT_W

## Operation
- Defaults: all ce=1, all nop=0, all Forward=00. Register x0 is never matched, forwarded or marked busy.
- E forwarding, per operand, only if valid and non-zero. Priority M over W:
  - match rd_M & we_M & !ld_M → 10
  - match rd_M & we_M & ld_M → load-use E-stall
  - otherwise match rd_W & we_W → 01 if ld_W, else 11
- E-stall: PC/IF_ID/ID_EX ce=0, EX_MEM_nop=1. Raised by a load-use hazard, or by long_issue_E while sb_cnt==MAX_LONG.
- D hazards. Branch/jump operands: match rd_E & we_E → D-stall; match M → stall if ld_M, else 10; match W → 01/11. Any valid D source, or rd_D with we_D, that hits a busy scoreboard bit → D-stall.
- D-stall: PC/IF_ID ce=0, ID_EX_nop=1.
- Priority: HALT > E-stall > redirect > D-stall.
  - Redirect (PCnew_E, E not stalled): IF_ID_nop=ID_EX_nop=1, all ce=1, Forward*D=00.
  - PCnew_E during an E-stall is ignored. It is re-evaluated when E advances.
- Scoreboard: E advances when there is no E-stall and state is RUN.
  - Set busy[rd_E] on long_issue_E & E advances & rd_E≠0.
  - Clear busy[long_rd] on long_done.
  - Set and clear of the same register in the same cycle: set wins.
  - long_done to a non-busy register: no change, sb_err←1 (sticky until rst).
  - sb_cnt = popcount(busy), registered.
- Halt FSM, states RUN, HALT, RESUME:
  - RUN→HALT on ebreak_E & E advances.
  - HALT: PC/IF_ID/ID_EX ce=0, EX_MEM_nop=1, halted=1. Long ops continue and long_done clears bits.
  - HALT→RESUME on resume_i.
  - RESUME: one cycle, all ce=1, ebreak_E ignored (the ebreak leaves E). Then →RUN.
- stall_cnt: +1 per cycle with PC_ce=0 and state≠HALT; saturates at all-ones.

## Timing
- Forward*, ce and nop outputs are combinational from the inputs and current state, with no added latency. Registered state is the FSM, busy, sb_err and stall_cnt.
- During rst: outputs are at their defaults. Next state is RUN, busy=0, sb_cnt=0, sb_err=0, stall_cnt=0, halted=0. Reset mid-HALT or with ops outstanding discards everything.
- Load-use costs exactly 1 bubble. A branch that depends on the instruction in E costs 1 cycle (2 if that instruction is a load).
- A busy bit cleared at edge N lets the dependent instruction in D advance in cycle N, with no extra bubble.
- A long issue with sb_cnt==MAX_LONG stalls until a long_done; issue proceeds the cycle after the count drops.
- HALT entry takes effect the cycle after ebreak_E. The minimum halt is 1 cycle; resume takes 1 cycle.

## Test plan
- `lw x5` then `add x6,x5,x7` → 1 cycle EX_MEM_nop=1, then ForwardAE=01; stall_cnt=1.
- `add x5`; `beq x5,x0` in D → 1 D-stall cycle, then ForwardAD=10.
- MAX_LONG=2: issue 3 divs to x8, x9, x10 → third holds with E-stall until long_done(x8). `add x11,x9,x0` in D stalls until long_done(x9). sb_cnt sequence 1,2,1,2,1.
- Same-cycle issue x8 + long_done x8 → busy[8] stays 1. long_done x12 (not busy) → sb_err=1 and stays 1.
- ebreak_E with a div outstanding → halted=1 the next cycle, long_done clears the bit while halted. resume_i → one RESUME cycle, then RUN. stall_cnt does not advance during HALT.
- PCnew_E while a load-use E-stall is active → redirect held off for 1 cycle, then IF_ID_nop=ID_EX_nop=1. Assert rst mid-HALT → all outputs at defaults, halted=0 the next cycle.
